// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers: shift-add multiply, restoring divide,
// one bit per cycle, followed by a single sign-fix cycle.
module mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mf_data,
  output logic             mf_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // acc: product upper half / division remainder; wrk: multiplier / quotient (dividend shifts out)
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   wrk_q, wrk_d;
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mf_data_q, mf_data_d;
  logic               mf_valid_q, mf_valid_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               valid_fn;
  logic               accept;
  logic               sgn;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shl;
  logic [WIDTH:0]     div_trial;
  logic               div_borrow;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               unused_aluop;

  assign unused_aluop = ^ALUOp[2:1];

  always_comb begin
    valid_fn = 1'b0;
    case (func)
      FnMfhi, FnMthi, FnMflo, FnMtlo, FnMult, FnMultu, FnDiv, FnDivu: valid_fn = 1'b1;
      default: valid_fn = 1'b0;
    endcase
    accept = issue & ALUOp[0] & (state_q == StIdle) & valid_fn;

    // Odd function codes are the unsigned variants.
    sgn   = ~func[0];
    a_neg = sgn & op_a[WIDTH-1];
    b_neg = sgn & op_b[WIDTH-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;

    mul_sum    = {1'b0, acc_q} + {1'b0, (wrk_q[0] ? bmag_q : {WIDTH{1'b0}})};
    div_shl    = {acc_q, wrk_q[WIDTH-1]};
    div_trial  = div_shl - {1'b0, bmag_q};
    div_borrow = div_trial[WIDTH];

    prod     = {acc_q, wrk_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -wrk_q : wrk_q;
    rem_fix  = neg_rem_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    wrk_d      = wrk_q;
    bmag_d     = bmag_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    is_div_d   = is_div_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mf_data_d  = mf_data_q;
    mf_valid_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (func)
            FnMfhi: begin
              mf_data_d  = hi_q;
              mf_valid_d = 1'b1;
            end
            FnMflo: begin
              mf_data_d  = lo_q;
              mf_valid_d = 1'b1;
            end
            FnMthi: hi_d = op_a;
            FnMtlo: lo_d = op_a;
            FnMult, FnMultu: begin
              state_d   = StMul;
              cnt_d     = CNT_W'(WIDTH);
              acc_d     = '0;
              wrk_d     = b_mag;
              bmag_d    = a_mag;
              neg_d     = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              dz_d      = 1'b0;
              is_div_d  = 1'b0;
            end
            FnDiv, FnDivu: begin
              acc_d     = '0;
              bmag_d    = b_mag;
              neg_d     = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              is_div_d  = 1'b1;
              if (op_b == '0) begin
                // Divide by zero skips the iterations; wrk carries the raw dividend to HI.
                state_d = StFix;
                dz_d    = 1'b1;
                wrk_d   = op_a;
              end else begin
                state_d = StDiv;
                cnt_d   = CNT_W'(WIDTH);
                dz_d    = 1'b0;
                wrk_d   = a_mag;
              end
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        acc_d = mul_sum[WIDTH:1];
        wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StDiv: begin
        acc_d = div_borrow ? div_shl[WIDTH-1:0] : div_trial[WIDTH-1:0];
        wrk_d = {wrk_q[WIDTH-2:0], ~div_borrow};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (dz_q) begin
          hi_d = wrk_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      wrk_q      <= '0;
      bmag_q     <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      is_div_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      mf_data_q  <= '0;
      mf_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      wrk_q      <= wrk_d;
      bmag_q     <= bmag_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      is_div_q   <= is_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mf_data_q  <= mf_data_d;
      mf_valid_q <= mf_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mf_data  = mf_data_q;
  assign mf_valid = mf_valid_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide unit with its own function decode and HI/LO registers; the sequential successor to the combinational ALU control decoder.
- Sits beside the ALU in EX. It accepts R-type mult/multu/div/divu/mfhi/mflo/mthi/mtlo and signals busy so the pipeline stalls.
- Datapath width is parametrised.
- Multiply is shift-add and divide is restoring, one bit per cycle, each followed by one sign-fix cycle.

Parameters:
- WIDTH, 32, operand/HI/LO width; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH+1), iteration counter width. Derived; must not be overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- issue  in  1  instruction present in EX this cycle.
- ALUOp  in  3  main-control op class; ALUOp[0]=1 marks R-type.
- func  in  6  R-type function field.
- op_a  in  WIDTH  rs value: dividend, multiplicand, or mthi/mtlo source.
- op_b  in  WIDTH  rt value: divisor or multiplier.
- busy  out  1  multi-cycle operation in flight; upstream must stall.
- done  out  1  one-cycle pulse: HI/LO updated by a mult/div.
- mf_data  out  WIDTH  registered mfhi/mflo result.
- mf_valid  out  1  one-cycle pulse qualifying mf_data.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: hi, lo, mf_data = 0; busy, done, mf_valid = 0; state = IDLE. Asserting rst mid-operation aborts it: no done pulse, HI/LO cleared.
- Accept condition: issue & ALUOp[0] & state==IDLE & func in {0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo, 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu}.
  - Anything else is ignored with no state change.
  - issue while busy is ignored; there is no queue.
- States:
  - IDLE.
  - MUL: WIDTH iterations. Each iteration adds the multiplicand magnitude when the multiplier LSB is 1, then shifts right.
  - DIV: WIDTH iterations. Each iteration shifts the remainder left, trial-subtracts the divisor magnitude, and restores on borrow.
  - FIX: apply signs, write HI/LO.
- Transitions:
  - IDLE->MUL or IDLE->DIV on accepted mult/div; counter = WIDTH.
  - MUL/DIV -> FIX on the edge where the counter reaches 0.
  - FIX -> IDLE unconditionally.
  - div/divu with op_b==0: IDLE->FIX directly.
- Timing for a normal operation, edge E0 = accept:
  - busy=1 from after E0 until E_{WIDTH+1}, i.e. WIDTH+1 cycles.
  - hi/lo are written at E_{WIDTH+1}.
  - done=1 for exactly the cycle after E_{WIDTH+1}; busy=0 in that cycle.
  - Divide-by-zero takes the same shape with busy for 1 cycle: done after E1.
- Sign and width rules:
  - Signed ops work on magnitudes; operands are sampled at accept.
  - Product is 2*WIDTH bits: hi = upper half, lo = lower half. Negate the full 2*WIDTH result when the signs differ.
  - Quotient truncates toward zero and goes to lo. Remainder takes the dividend's sign and goes to hi.
  - div MIN/-1: lo = MIN, hi = 0 (natural wrap, no trap).
  - Divide by zero (both div and divu): hi = op_a, lo = all ones.
- mthi/mtlo: hi/lo written at the accept edge. No busy, no done.
- mfhi/mflo: at the accept edge, mf_data <= hi or lo, and mf_valid=1 for the next cycle.
  - In the done cycle the unit is IDLE, so mfhi/mflo is accepted and reads the new HI/LO.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- WIDTH=32, mult op_a=0xFFFFFFFD (-3), op_b=5 -> busy 33 cycles; done after E33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then mfhi -> mf_data=0xFFFFFFFE with mf_valid pulse.
- div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu 0x1234/0 -> busy 1 cycle; done after E1; hi=0x00001234, lo=0xFFFFFFFF.
- mult in flight, rst asserted at cycle 10 -> hi=lo=0, busy=0, no done. A second mult issued while busy (no reset) is ignored, and the original result is unchanged.
- WIDTH=8, mthi 0x5A, then ALUOp[0]=0 with func=0x10 -> no mf_valid. Then a valid mfhi -> mf_data=0x5A.
